fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage. Owns the PC, drives the byte-addressed, combinational-read
//  instruction memory (address + enable), and captures each returned 32-bit word with
//  its PC into a 2-entry queue. The queue feeds the decode stage over a valid/ready
//  handshake. Accepts branch/jump redirects from downstream and flags illegal fetch targets.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  IMEM_BYTES  128            instruction memory size in bytes; power of two, multiple of 4
//  QDEPTH      2              fetch queue depth (fixed at 2; other values unsupported)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   reset; asynchronous, active-low
//  imem_addr       out  32  byte address of the fetched word (= pc)
//  imem_en         out  1   read enable to the instruction memory
//  imem_instr      in   32  word returned combinationally in the same cycle
//  redirect_valid  in   1   redirect request (taken branch/jump); single-cycle pulse
//  redirect_pc     in   32  redirect target byte address
//  id_valid        out  1   queue head valid toward decode
//  id_ready        in   1   decode accepts the head this cycle
//  id_instr        out  32  head instruction word
//  id_pc           out  32  head PC
//  fetch_fault     out  1   sticky: illegal redirect target; fetch halted
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (rst low clears state immediately).
//   pc=RESET_PC, queue empty, state=RUN, id_valid=0, id_instr=0, id_pc=0,
//   fetch_fault=0, imem_en=0 while rst is low.
//  States: RUN (fetch), HALT (no fetch; fetch_fault=1).
//  Fetch fire (RUN, !redirect_valid, queue has room): imem_en=1, imem_addr=pc; the
//   {pc, imem_instr} pair is pushed at the edge and pc advances by 4.
//  Room: count<2, or count==2 with a pop this cycle (id_valid & id_ready). Otherwise
//   imem_en=0 and pc holds.
//  Sequential wrap: pc advances to 0 when pc+4 == IMEM_BYTES. This is not a fault.
//  Latency: a word fetched in cycle N is on id_* in cycle N+1 when the queue was empty.
//   id_* come straight from the queue head register, with no combinational path from imem_instr.
//  Pop: id_valid & id_ready removes the head. id_instr/id_pc are stable while id_valid & !id_ready.
//  Redirect (redirect_valid=1 in cycle N):
//   - imem_en=0 in cycle N; no push in cycle N.
//   - A pop handshake in cycle N still completes.
//   - At the edge the queue is flushed, giving id_valid=0 in N+1.
//   - Legal target (aligned [1:0]==0 and < IMEM_BYTES): pc=redirect_pc, state=RUN.
//     Target is fetched in N+1 and visible on id_* in N+2.
//   - Illegal target: state=HALT, fetch_fault=1, pc unchanged.
//  HALT: imem_en=0, queue stays empty. Exit only via a legal redirect (fault clears at
//   that edge) or reset.
//  Simultaneous push+pop at count==2: count stays 2. Head advances, new tail is written.
//  Reset mid-operation: queue contents discarded; the first fetch after release is RESET_PC.
//  Queue pointers are 1-bit with wrap; count is 2 bits (0..2).
// STRUCTURE
//  cpu_pkg:
//   - INSTR_W=32, ADDR_W=32
//   - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t
//   - fetch_state_t enum {RUN, HALT}
//  Sub-module fetch_queue: 2-entry synchronous FIFO of fetch_entry_t.
//   - Inputs: push, pop, flush (flush dominates push, applied at the same edge).
//   - Outputs: head, valid, full.
//  fetch_unit top holds the PC register, the state FSM, and the fire/room/redirect logic.
// TESTING (bench models the memory as a combinational byte array, big-endian word assembly)
//  1 Reset, id_ready=1, mem word k = 32'h1000_0000+k -> id_pc 0,4,8,... on consecutive cycles
//    from cycle 1 after release; id_instr matches.
//  2 id_ready=0 for 5 cycles -> queue fills to 2, imem_en=0, pc holds at 8. Head stays
//    pc=0 stable. Release -> pc 0,4,8 delivered in order, with no loss or duplicate.
//  3 Redirect to 32'h40 while queue holds 2 entries and id_ready=1 -> that cycle's pop
//    completes, id_valid=0 next cycle, id_pc=32'h40 two cycles after the redirect.
//  4 Sequential fetch to pc=124 with IMEM_BYTES=128 -> next id_pc=0, fetch_fault stays 0.
//  5 Redirect to 32'h42 (misaligned), then to 32'h80 (out of range) -> fetch_fault=1,
//    imem_en=0 held. A later redirect to 32'h10 -> fault clears, id_pc=32'h10 two cycles later.
//  6 Assert rst low mid-stream with a full queue -> id_valid=0 and imem_en=0 immediately.
//    After release the first id_pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: queue entry layout, fetch FSM states and PC sequencing helper.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Sequential successor of pc; wraps to 0 at the end of instruction memory.
    function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] pc,
                                                      input logic [ADDR_W-1:0] limit);
        logic [ADDR_W-1:0] nxt;
        nxt = pc + 32'd4;
        return (nxt == limit) ? '0 : nxt;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and the decode handshake.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               fetch_fault;

    modport master (
        output imem_addr, imem_en, id_valid, id_instr, id_pc, fetch_fault,
        input  imem_instr, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, imem_en, id_valid, id_instr, id_pc, fetch_fault,
        output imem_instr, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// Two-entry fetch FIFO; flush empties it at the edge and overrides a same-cycle push.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic         full_o
);

    localparam logic [1:0] CNT_FULL = 2'(QDEPTH);

    logic [1:0]   count_q, count_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         do_push, do_pop;
    fetch_entry_t mem_q [2];

    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == CNT_FULL);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is cleared on reset so the decode-side head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, RUN/HALT control, memory request and the decode queue.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128,
    parameter int unsigned QDEPTH     = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master fu
);

    localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_BYTES);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    fetch_entry_t      q_head, q_push_data;
    logic              q_valid, q_full;
    logic              pop, room, fire, redir_legal;

    assign pop         = q_valid & fu.id_ready;
    assign room        = ~q_full | pop;
    assign redir_legal = (fu.redirect_pc[1:0] == 2'b00) && (fu.redirect_pc < IMEM_LIMIT);
    assign q_push_data = '{pc: pc_q, instr: fu.imem_instr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fu.redirect_valid) state_d = redir_legal ? RUN : HALT;
    end

    // The memory request is suppressed while reset is held low, independent of state.
    always_comb begin
        fire           = rst && (state_q == RUN) && !fu.redirect_valid && room;
        fu.fetch_fault = (state_q == HALT);
    end

    always_comb begin
        pc_d = pc_q;
        if (fu.redirect_valid) begin
            if (redir_legal) pc_d = fu.redirect_pc;
        end else if (fire) begin
            pc_d = next_seq_pc(pc_q, IMEM_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fire),
        .pop_i   (pop),
        .flush_i (fu.redirect_valid),
        .data_i  (q_push_data),
        .head_o  (q_head),
        .valid_o (q_valid),
        .full_o  (q_full)
    );

    assign fu.imem_en   = fire;
    assign fu.imem_addr = pc_q;
    assign fu.id_valid  = q_valid;
    assign fu.id_instr  = q_head.instr;
    assign fu.id_pc     = q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int IMEM = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] mem [IMEM];

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM), .QDEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .fu  (bus)
    );

    always #5 clk = ~clk;

    // Combinational big-endian word read from the byte array.
    assign bus.imem_instr = {mem[{bus.imem_addr[6:2], 2'b00}], mem[{bus.imem_addr[6:2], 2'b01}],
                             mem[{bus.imem_addr[6:2], 2'b10}], mem[{bus.imem_addr[6:2], 2'b11}]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Reference model: a plain queue of (pc, instr) pairs, a pc and a halted flag.
    fetch_entry_t mq[$];
    logic [31:0]  mpc   = 32'h0;
    bit           mhalt = 1'b0;

    always @(negedge clk) begin
        bit   pop, en, legal;
        if (!rst) begin
            mq.delete();
            mpc   = 32'h0;
            mhalt = 1'b0;
            chk("m_rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
            chk("m_rst_imem_en", {31'b0, bus.imem_en}, 32'd0);
            chk("m_rst_fault", {31'b0, bus.fetch_fault}, 32'd0);
            chk("m_rst_id_pc", bus.id_pc, 32'd0);
            chk("m_rst_id_instr", bus.id_instr, 32'd0);
        end else begin
            pop = (mq.size() > 0) && bus.id_ready;
            en  = !mhalt && !bus.redirect_valid && ((mq.size() < 2) || pop);
            chk("m_id_valid", {31'b0, bus.id_valid}, {31'b0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("m_id_pc", bus.id_pc, mq[0].pc);
                chk("m_id_instr", bus.id_instr, mq[0].instr);
            end
            chk("m_imem_en", {31'b0, bus.imem_en}, {31'b0, en});
            if (en) chk("m_imem_addr", bus.imem_addr, mpc);
            chk("m_fault", {31'b0, bus.fetch_fault}, {31'b0, mhalt});
            if (bus.redirect_valid) begin
                mq.delete();
                legal = (bus.redirect_pc % 4 == 0) && (bus.redirect_pc < IMEM);
                if (legal) begin
                    mpc   = bus.redirect_pc;
                    mhalt = 1'b0;
                end else begin
                    mhalt = 1'b1;
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (en) begin
                    mq.push_back('{pc: mpc, instr: word_at(mpc)});
                    mpc = (mpc + 4) % IMEM;
                end
            end
        end
    end

    task automatic cyc(input bit rv, input logic [31:0] rpc, input bit rdy);
        @(posedge clk);
        #1;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        #1;
    endtask

    task automatic assert_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b0;
        #1;
    endtask

    task automatic release_rst(input bit rdy);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.id_ready       = rdy;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int k = 0; k < IMEM / 4; k++) begin
            logic [31:0] w;
            w = 32'h1000_0000 + k;
            mem[4*k]   = w[31:24];
            mem[4*k+1] = w[23:16];
            mem[4*k+2] = w[15:8];
            mem[4*k+3] = w[7:0];
        end
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        #2;
        chk("reset_id_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("reset_imem_en", {31'b0, bus.imem_en}, 32'd0);
        chk("reset_id_pc", bus.id_pc, 32'd0);
        repeat (2) @(posedge clk);

        // Streaming from reset
        release_rst(1'b1);
        chk("s1_first_en", {31'b0, bus.imem_en}, 32'd1);
        chk("s1_first_addr", bus.imem_addr, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("s1_id_valid", {31'b0, bus.id_valid}, 32'd1);
            chk("s1_id_pc", bus.id_pc, 32'(4 * i));
            chk("s1_id_instr", bus.id_instr, 32'h1000_0000 + 32'(i));
        end

        // Backpressure fills the queue and holds the pc
        assert_rst();
        repeat (2) @(posedge clk);
        release_rst(1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b0);
            chk("s2_hold_en", {31'b0, bus.imem_en}, 32'd0);
            chk("s2_hold_pc", bus.imem_addr, 32'h8);
            chk("s2_head_pc", bus.id_pc, 32'h0);
        end
        cyc(1'b0, 32'h0, 1'b1);
        chk("s2_rel_pc0", bus.id_pc, 32'h0);
        chk("s2_rel_addr", bus.imem_addr, 32'h8);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s2_rel_pc4", bus.id_pc, 32'h4);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s2_rel_pc8", bus.id_pc, 32'h8);

        // Redirect with a full queue
        cyc(1'b1, 32'h40, 1'b1);
        chk("s3_redir_en", {31'b0, bus.imem_en}, 32'd0);
        chk("s3_redir_pop_pc", bus.id_pc, 32'hC);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s3_flushed", {31'b0, bus.id_valid}, 32'd0);
        chk("s3_fetch_addr", bus.imem_addr, 32'h40);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s3_target_pc", bus.id_pc, 32'h40);
        chk("s3_target_instr", bus.id_instr, 32'h1000_0010);

        // Sequential wrap at the end of memory
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            if (bus.id_valid && bus.id_pc == 32'd124) found = 1'b1;
        end
        chk("s4_reach_124", {31'b0, found}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s4_wrap_pc", bus.id_pc, 32'h0);
        chk("s4_wrap_fault", {31'b0, bus.fetch_fault}, 32'd0);

        // Illegal redirects halt fetch; a legal one recovers
        cyc(1'b1, 32'h42, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s5_misalign_fault", {31'b0, bus.fetch_fault}, 32'd1);
        chk("s5_misalign_en", {31'b0, bus.imem_en}, 32'd0);
        cyc(1'b1, 32'h80, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s5_range_fault", {31'b0, bus.fetch_fault}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s5_halt_en", {31'b0, bus.imem_en}, 32'd0);
        cyc(1'b1, 32'h10, 1'b1);
        chk("s5_fault_before_edge", {31'b0, bus.fetch_fault}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s5_fault_cleared", {31'b0, bus.fetch_fault}, 32'd0);
        chk("s5_resume_addr", bus.imem_addr, 32'h10);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s5_resume_pc", bus.id_pc, 32'h10);

        // Asynchronous reset with a full queue
        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        assert_rst();
        chk("s6_async_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("s6_async_en", {31'b0, bus.imem_en}, 32'd0);
        repeat (2) @(posedge clk);
        release_rst(1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("s6_first_pc", bus.id_pc, 32'h0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0:       tgt = {25'b0, $urandom_range(0, 31) % 32 == 0 ? 5'd1 : 5'($urandom_range(0, 31)), 2'b10};
                1:       tgt = 32'(IMEM) + 32'(4 * $urandom_range(0, 15));
                default: tgt = 32'(4 * $urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 149) == 0) begin
                assert_rst();
                release_rst(1'b1);
            end else begin
                cyc($urandom_range(0, 11) == 0, tgt, $urandom_range(0, 3) != 0);
            end
        end
        cyc(1'b0, 32'h0, 1'b1);
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
